// File: rtl/apb_multi_bank_slave.sv
// APB completer serving NUM_SEL independent register banks of DEPTH words each,
// with programmable wait states, SLVERR on bad accesses and protocol-violation abort.
module apb_multi_bank_slave #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SEL = 4,
  parameter int DEPTH   = 16,
  parameter int WAIT_W  = 4
) (
  input  logic               pclk,
  input  logic               prst,
  input  logic [NUM_SEL-1:0] psel,
  input  logic [ADDR_W-1:0]  paddr,
  input  logic [DATA_W-1:0]  pwdata,
  input  logic               pwrite,
  input  logic               penable,
  input  logic [WAIT_W-1:0]  wait_cfg,
  output logic               pready,
  output logic [1:0]         presp,
  output logic [DATA_W-1:0]  prdata,
  output logic               pviol
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BANK_W = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic [1:0]        presp_q, presp_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pviol_q, pviol_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               write_q;
  logic [NUM_SEL-1:0] sel_q;
  logic               err_q;
  logic [BANK_W-1:0]  bank_q;
  logic [IDX_W-1:0]   idx_q;

  logic [DATA_W-1:0] mem_q [NUM_SEL][DEPTH];

  logic              setup, err_in, violation, commit;
  logic [BANK_W-1:0] bank_in;
  logic [IDX_W-1:0]  idx_in;

  function automatic logic [1:0] resp_code(input logic err);
    return err ? 2'b10 : 2'b00;
  endfunction

  always_comb begin
    bank_in = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (psel[i]) bank_in = BANK_W'(i);
    end
  end

  assign idx_in = paddr[IDX_W+1:2];
  assign setup  = (|psel) && !penable;
  // Bad select, misaligned or past the end of the bank: answered with SLVERR.
  assign err_in = ((psel & (psel - NUM_SEL'(1))) != '0) ||
                  (paddr[1:0] != 2'b00) ||
                  ((paddr >> (IDX_W + 2)) != '0);
  assign violation = !penable || (psel != sel_q) || (paddr != addr_q) || (pwrite != write_q);
  assign commit    = (state_q == S_ACCESS) && pready_q && write_q && !err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = pready_q;
    presp_d  = presp_q;
    prdata_d = prdata_q;
    pviol_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
          cnt_d   = wait_cfg;
          if (wait_cfg == '0) begin
            pready_d = 1'b1;
            presp_d  = resp_code(err_in);
            prdata_d = (err_in || pwrite) ? '0 : mem_q[bank_in][idx_in];
          end
        end else if (penable) begin
          pviol_d = 1'b1;
        end
      end
      default: begin
        if (pready_q) begin
          state_d  = S_IDLE;
          pready_d = 1'b0;
          presp_d  = 2'b00;
          prdata_d = '0;
        end else if (violation) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pviol_d = 1'b1;
        end else if (cnt_q > WAIT_W'(1)) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          cnt_d    = '0;
          pready_d = 1'b1;
          presp_d  = resp_code(err_q);
          prdata_d = (err_q || write_q) ? '0 : mem_q[bank_q][idx_q];
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      presp_q  <= 2'b00;
      prdata_q <= '0;
      pviol_q  <= 1'b0;
      for (int b = 0; b < NUM_SEL; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      presp_q  <= presp_d;
      prdata_q <= prdata_d;
      pviol_q  <= pviol_d;
      if (commit) mem_q[bank_q][idx_q] <= wdata_q;
    end
  end

  // Transfer attributes captured at setup; compared against the bus to spot violations.
  always_ff @(posedge pclk) begin
    if ((state_q == S_IDLE) && setup) begin
      addr_q  <= paddr;
      wdata_q <= pwdata;
      write_q <= pwrite;
      sel_q   <= psel;
      err_q   <= err_in;
      bank_q  <= bank_in;
      idx_q   <= idx_in;
    end
  end

  assign pready = pready_q;
  assign presp  = presp_q;
  assign prdata = prdata_q;
  assign pviol  = pviol_q;

endmodule
